instruction_store: RTL
======================

INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, meaning the number of 32-bit instruction words (address width 5).
REQ-002 SHALL provide parameter NOP_INSTR, default 32'hF1A00000, meaning the word returned for unwritten addresses.
REQ-003 SHALL have port clk  input  1  system clock, one clock domain, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port write_ins  input  1  write strobe from the program loader.
REQ-006 SHALL have port ins_address  input  5  write address.
REQ-007 SHALL have port ins  input  32  instruction word to store.
REQ-008 SHALL have port run  input  1  level signal; high means the processor is released and executing.
REQ-009 SHALL have port fetch_req  input  1  fetch request from the processor fetch stage.
REQ-010 SHALL have port pc  input  5  fetch address.
REQ-011 SHALL have port instr  output  32  fetched instruction, registered.
REQ-012 SHALL have port fetch_valid  output  1  one-cycle pulse marking instr as valid.
REQ-013 SHALL have port fetch_miss  output  1  one-cycle pulse: the fetched address was never written.
REQ-014 SHALL have port loading  output  1  high while the state is LOADING.
REQ-015 SHALL have port valid_count  output  6  number of distinct addresses written since reset.
REQ-016 SHALL have port cond_err  output  1  sticky flag: a word was written whose condition field [31:28] is not 4'b1111.

Function
REQ-017 SHALL implement states EMPTY, LOADING and READY.
REQ-018 SHALL move EMPTY->LOADING and READY->LOADING on any cycle with write_ins=1.
REQ-019 SHALL move LOADING->READY on a cycle with run=1 and write_ins=0; a write with run=1 leaves the state in LOADING.
REQ-020 SHALL stay in EMPTY when run=1 arrives and no write has occurred.
REQ-021 SHALL store ins into mem[ins_address] and set valid[ins_address] at the rising edge on which write_ins=1, in any state.
REQ-022 SHALL treat repeated writes to the same address (write_ins held for several cycles) as idempotent: last data wins, valid_count increments only on a 0->1 transition of valid.
REQ-023 SHALL limit valid_count to the range 0..32; it SHALL NOT wrap.
REQ-024 SHALL set cond_err on a write with ins[31:28]!=4'hF; the word is still stored; cond_err stays set until reset.
REQ-025 SHALL give a fetch latency of 1 cycle: when fetch_req=1 is seen at edge N, instr and fetch_valid are updated at edge N+1.
REQ-026 SHALL respond to a fetch only in READY; in EMPTY or LOADING fetch_valid stays 0 and instr holds its value (stall).
REQ-027 SHALL return NOP_INSTR and pulse fetch_miss together with fetch_valid when a fetch in READY hits an address with valid=0.
REQ-028 SHALL make fetch_valid and fetch_miss single-cycle pulses; back-to-back fetch_req SHALL give back-to-back responses.
REQ-029 SHALL be write-first on a same-cycle write and fetch to one address: a fetch in READY coincident with a write is not served, because the write moves the state to LOADING at that edge.

Reset
REQ-030 SHALL, with reset=1 at a rising edge, set the state to EMPTY, clear the valid bitmap, and clear instr to NOP_INSTR, fetch_valid, fetch_miss, loading, valid_count and cond_err to 0.
REQ-031 SHALL NOT clear memory contents on reset; unwritten-ness is tracked by valid only.
REQ-032 SHALL give reset priority over write_ins, run and fetch_req in the same cycle; a load in progress is abandoned.

Structure
REQ-033 SHALL place the state enum, NOP_INSTR, COND_ALWAYS (4'hF) and the address width in the shared package.
REQ-034 SHALL keep the storage array and registered read port in one sub-module, instr_ram (32x32, synchronous write, registered read); valid bitmap, counter and FSM stay in the top level.

Verification
REQ-035 SHALL cover: write 0xF3800012 @0 and 0xF080F001 @8, then run=1, then fetch pc=8 -> next cycle instr=0xF080F001, fetch_valid=1, fetch_miss=0.
REQ-036 SHALL cover: in READY, fetch pc=3 (never written) -> instr=0xF1A00000, fetch_valid=1, fetch_miss=1, valid_count=2.
REQ-037 SHALL cover: write_ins held 4 cycles @5 with changing data -> mem[5] = last data, valid_count increases by exactly 1.
REQ-038 SHALL cover: write 0xE3800001 -> cond_err=1 and stays 1 through later writes and run; reset -> 0.
REQ-039 SHALL cover: fetch_req in LOADING (run=0) -> no fetch_valid; write during READY -> loading=1 at the next edge and fetches stall until run=1.
REQ-040 SHALL cover: reset asserted mid-load after 3 writes -> state EMPTY, valid_count=0; run=1 then fetch pc=0 -> no response.

Source files
------------

// File: rtl/instruction_store_pkg.sv
// Shared definitions for the instruction store: fetch-side states,
// address width and the reserved instruction encodings.
package instruction_store_pkg;

    localparam int          ADDR_W      = 5;
    localparam logic [31:0] NOP_INSTR   = 32'hF1A00000;
    localparam logic [3:0]  COND_ALWAYS = 4'hF;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_READY
    } state_t;

endpackage

// File: rtl/instruction_store_ram.sv
// Instruction word storage: synchronous write, registered read port.
// Contents survive reset; only the read register is reset.
module instr_ram
    import instruction_store_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] RST_WORD = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              force_nop,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // force_nop substitutes the filler word for addresses never written
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= RST_WORD;
        else if (re)
            rdata <= force_nop ? RST_WORD : mem[raddr];
    end

endmodule

// File: rtl/instruction_store.sv
// Instruction store: loader writes words, processor fetches them once
// released by run. Tracks written addresses, word count and bad conditions.
module instruction_store #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] NOP_INSTR = instruction_store_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_ins,
    input  logic [4:0]  ins_address,
    input  logic [31:0] ins,
    input  logic        run,
    input  logic        fetch_req,
    input  logic [4:0]  pc,
    output logic [31:0] instr,
    output logic        fetch_valid,
    output logic        fetch_miss,
    output logic        loading,
    output logic [5:0]  valid_count,
    output logic        cond_err
);

    import instruction_store_pkg::*;

    state_t           state;
    logic [DEPTH-1:0] valid;
    logic             serve;
    logic             new_addr;

    // Any write this cycle pulls the state to LOADING, so it also blocks fetch
    assign serve    = (state == ST_READY) && fetch_req && !write_ins;
    assign new_addr = write_ins && !valid[ins_address];

    instr_ram #(
        .DEPTH    (DEPTH),
        .RST_WORD (NOP_INSTR)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .we        (write_ins && !reset),
        .waddr     (ins_address),
        .wdata     (ins),
        .re        (serve),
        .raddr     (pc),
        .force_nop (!valid[pc]),
        .rdata     (instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            loading     <= 1'b0;
            valid       <= '0;
            valid_count <= '0;
            cond_err    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_miss  <= 1'b0;
        end else begin
            fetch_valid <= serve;
            fetch_miss  <= serve && !valid[pc];

            if (write_ins) begin
                valid[ins_address] <= 1'b1;
                if (new_addr && (valid_count < 6'(DEPTH)))
                    valid_count <= valid_count + 6'd1;
                if (ins[31:28] != COND_ALWAYS)
                    cond_err <= 1'b1;
            end

            unique case (state)
                ST_EMPTY, ST_READY: begin
                    if (write_ins) begin
                        state   <= ST_LOADING;
                        loading <= 1'b1;
                    end
                end
                ST_LOADING: begin
                    if (run && !write_ins) begin
                        state   <= ST_READY;
                        loading <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    loading <= 1'b0;
                end
            endcase
        end
    end

endmodule
